// File: rtl/invader_alive_map_pkg.sv
// invaders_pkg: shared sizes, FSM states and scoring helpers for invader_alive_map.
// to_bcd is used by score_accum when INVADER_SCORE_BCD_EN is defined.
package invaders_pkg;

  localparam int NUM_ROWS     = 3;
  localparam int NUM_INVADERS = 10;
  localparam int POINTS_BASE  = 10;
  localparam int ROW_W        = $clog2(NUM_ROWS);
  localparam int COL_W        = $clog2(NUM_INVADERS);

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    PLAY,
    DONE
  } alive_state_t;

  typedef logic [ROW_W-1:0] row_idx_t;
  typedef logic [COL_W-1:0] col_idx_t;

  // Lower rows are closer to the player, so row 0 is worth the most.
  function automatic logic [15:0] row_points(
    input int row,
    input int nrows = NUM_ROWS,
    input int base  = POINTS_BASE
  );
    return 16'((nrows - row) * base);
  endfunction

  // Four packed BCD digits of a value below 10000.
  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0]  r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/invader_alive_map_score_accum.sv
// score_accum: saturating score register with clear-over-add priority.
// INVADER_SCORE_BCD_EN selects a 4-digit BCD score saturating at 9999.
module score_accum
  import invaders_pkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               add_en,
  input  logic [15:0]        add_pts,
  output logic [SCORE_W-1:0] score
);

`ifdef INVADER_SCORE_BCD_EN

  logic [15:0] score_q;
  logic [15:0] score_d;
  logic [15:0] pts_bcd;
  logic [15:0] sum;
  logic        carry;
  logic [4:0]  ds;

  // Digit-serial BCD add; a carry out of the top digit saturates.
  always_comb begin
    pts_bcd = to_bcd(32'(add_pts));
    carry   = 1'b0;
    sum     = '0;
    ds      = '0;
    for (int i = 0; i < 4; i++) begin
      ds = 5'(score_q[4*i+:4]) + 5'(pts_bcd[4*i+:4]) + 5'(carry);
      if (ds > 5'd9) begin
        ds    = ds + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i+:4] = ds[3:0];
    end
    score_d = score_q;
    if (clr) begin
      score_d = '0;
    end else if (add_en) begin
      score_d = carry ? 16'h9999 : sum;
    end
  end

  // Score register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = SCORE_W'(score_q);

`else

  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;
  logic [SCORE_W:0]   sum;

  // Binary add with the carry-out used as the saturation flag.
  always_comb begin
    sum     = {1'b0, score_q} + (SCORE_W+1)'(add_pts);
    score_d = score_q;
    if (clr) begin
      score_d = '0;
    end else if (add_en) begin
      score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end
  end

  // Score register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

`endif

endmodule

// File: rtl/invader_alive_map.sv
// invader_alive_map: alive mask, kill handling, wave FSM and score.
// INVADER_SCORE_BCD_EN switches the score to packed BCD (see score_accum).
module invader_alive_map #(
  parameter int NUM_INVADERS = invaders_pkg::NUM_INVADERS,
  parameter int NUM_ROWS     = invaders_pkg::NUM_ROWS,
  parameter int POINTS_BASE  = invaders_pkg::POINTS_BASE,
  parameter int SCORE_W      = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      new_wave,
  input  logic                                      score_clr,
  input  logic                                      hit_valid,
  output logic                                      hit_ready,
  input  logic [$clog2(NUM_ROWS)-1:0]               hit_row,
  input  logic [$clog2(NUM_INVADERS)-1:0]           hit_col,
  output logic [NUM_ROWS-1:0][NUM_INVADERS-1:0]     alive,
  output logic [$clog2(NUM_ROWS*NUM_INVADERS+1)-1:0] alive_count,
  output logic [SCORE_W-1:0]                        score,
  output logic                                      kill_pulse,
  output logic                                      wave_cleared,
  output logic                                      busy
);

  import invaders_pkg::*;

  localparam int RW    = $clog2(NUM_ROWS);
  localparam int CW    = $clog2(NUM_INVADERS);
  localparam int CNT_W = $clog2(NUM_ROWS*NUM_INVADERS+1);

  alive_state_t                          state_q, state_d;
  logic [RW-1:0]                         row_q, row_d;
  logic [NUM_ROWS-1:0][NUM_INVADERS-1:0] alive_q, alive_d;
  logic [NUM_ROWS-1:0][NUM_INVADERS-1:0] hit_sel;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic                                  kill_q, kill_d;
  logic                                  clr_q, clr_d;
  logic                                  hit_bit;
  logic                                  do_kill;
  logic [15:0]                           pts;

  // One-hot select of the addressed cell; out-of-range indices select nothing.
  always_comb begin
    hit_sel = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_INVADERS; c++) begin
        if (hit_row == RW'(r) && hit_col == CW'(c)) begin
          hit_sel[r][c] = 1'b1;
        end
      end
    end
  end

  assign hit_bit   = |(hit_sel & alive_q);
  assign hit_ready = (state_q == PLAY) && !new_wave;
  assign do_kill   = hit_valid && hit_ready && hit_bit;
  assign pts       = row_points(int'(hit_row), NUM_ROWS, POINTS_BASE);

  // Wave FSM: fill rows, consume hits, detect the cleared wave.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    alive_d = alive_q;
    cnt_d   = cnt_q;
    kill_d  = 1'b0;
    clr_d   = 1'b0;
    unique case (state_q)
      EMPTY, DONE: begin
        if (new_wave) begin
          state_d = FILL;
          row_d   = '0;
        end
      end
      FILL: begin
        alive_d[row_q] = '1;
        cnt_d = cnt_q + CNT_W'(NUM_INVADERS);
        if (row_q == RW'(NUM_ROWS-1)) begin
          state_d = PLAY;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      PLAY: begin
        if (new_wave) begin
          state_d = FILL;
          row_d   = '0;
          alive_d = '0;
          cnt_d   = '0;
        end else if (do_kill) begin
          alive_d = alive_q & ~hit_sel;
          cnt_d   = cnt_q - CNT_W'(1);
          kill_d  = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            clr_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, mask and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      row_q   <= '0;
      alive_q <= '0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      alive_q <= alive_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      clr_q   <= clr_d;
    end
  end

  score_accum #(
    .SCORE_W(SCORE_W)
  ) u_score (
    .clk    (clk),
    .rst    (rst),
    .clr    (score_clr),
    .add_en (do_kill),
    .add_pts(pts),
    .score  (score)
  );

  assign alive        = alive_q;
  assign alive_count  = cnt_q;
  assign kill_pulse   = kill_q;
  assign wave_cleared = clr_q;
  assign busy         = (state_q == FILL);

endmodule

// File: tb/tb_invader_alive_map.sv
// tb_invader_alive_map: directed stimulus, per-cycle model compare, literal pins.
// Define INVADER_SCORE_BCD_EN to exercise the BCD score build.
module tb_invader_alive_map;

  localparam int R = 3;
  localparam int C = 10;
`ifdef INVADER_SCORE_BCD_EN
  localparam int MAXS = 9999;
`else
  localparam int MAXS = 65535;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        new_wave = 1'b0;
  logic        score_clr = 1'b0;
  logic        hit_valid = 1'b0;
  logic [1:0]  hit_row = '0;
  logic [3:0]  hit_col = '0;
  logic        hit_ready;
  logic [2:0][9:0] alive;
  logic [4:0]  alive_count;
  logic [15:0] score;
  logic        kill_pulse;
  logic        wave_cleared;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  invader_alive_map dut (
    .clk         (clk),
    .rst         (rst),
    .new_wave    (new_wave),
    .score_clr   (score_clr),
    .hit_valid   (hit_valid),
    .hit_ready   (hit_ready),
    .hit_row     (hit_row),
    .hit_col     (hit_col),
    .alive       (alive),
    .alive_count (alive_count),
    .score       (score),
    .kill_pulse  (kill_pulse),
    .wave_cleared(wave_cleared),
    .busy        (busy)
  );

  // Model: a grid of live invaders, rows still to fill, and an integer score.
  bit m [R][C];
  int fill_left = 0;
  bit armed = 0;
  int mscore = 0;
  bit mkp = 0;
  bit mwc = 0;
  bit started = 0;

  function automatic int pop();
    int n = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        n += int'(m[r][c]);
    return n;
  endfunction

  function automatic logic [29:0] mask_vec();
    logic [2:0][9:0] v;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        v[r][c] = m[r][c];
    return v;
  endfunction

  function automatic logic [15:0] bcd(input int v);
    logic [15:0] o;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      o[4*i+:4] = 4'(t % 10);
      t = t / 10;
    end
    return o;
  endfunction

  function automatic logic [15:0] exp_score();
`ifdef INVADER_SCORE_BCD_EN
    return bcd(mscore);
`else
    return 16'(mscore);
`endif
  endfunction

  task automatic clear_grid();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        m[r][c] = 0;
  endtask

  task automatic model_step();
    int pts;
    pts = 0;
    started = 1;
    if (!rst) begin
      clear_grid();
      fill_left = 0;
      armed = 0;
      mscore = 0;
      mkp = 0;
      mwc = 0;
    end else begin
      mkp = 0;
      mwc = 0;
      if (fill_left > 0) begin
        for (int c = 0; c < C; c++) m[R-fill_left][c] = 1;
        fill_left--;
        if (fill_left == 0) armed = 1;
      end else if (new_wave) begin
        clear_grid();
        fill_left = R;
        armed = 0;
      end else if (armed && hit_valid && int'(hit_row) < R &&
                   int'(hit_col) < C) begin
        if (m[hit_row][hit_col]) begin
          m[hit_row][hit_col] = 0;
          mkp = 1;
          pts = (R - int'(hit_row)) * 10;
          if (pop() == 0) begin
            mwc = 1;
            armed = 0;
          end
        end
      end
      if (score_clr) mscore = 0;
      else if (mkp) mscore = (mscore + pts > MAXS) ? MAXS : mscore + pts;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic hit(input int r, input int c);
    hit_valid = 1'b1;
    hit_row = 2'(r);
    hit_col = 4'(c);
    cyc();
    hit_valid = 1'b0;
  endtask

  task automatic wave();
    new_wave = 1'b1;
    cyc();
    new_wave = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic kill_all();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        hit(r, c);
  endtask

  task automatic lit_score(input string name, input logic [15:0] b,
                           input logic [15:0] n);
`ifdef INVADER_SCORE_BCD_EN
    check(name, 32'(score), 32'(b));
`else
    check(name, 32'(score), 32'(n));
`endif
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("alive", 32'(alive), 32'(mask_vec()));
        check("alive_count", 32'(alive_count), 32'(pop()));
        check("score", 32'(score), 32'(exp_score()));
        check("kill_pulse", 32'(kill_pulse), 32'(mkp));
        check("wave_cleared", 32'(wave_cleared), 32'(mwc));
        check("busy", 32'(busy), 32'(fill_left > 0));
        check("hit_ready", 32'(hit_ready), 32'(armed && !new_wave));
      end
    end
  end

  initial begin
    rst = 1'b0;
    cyc();
    cyc();
    check("rst_score", 32'(score), 0);
    check("rst_count", 32'(alive_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(hit_ready), 0);
    rst = 1'b1;

    new_wave = 1'b1;
    cyc();
    new_wave = 1'b0;
    check("fill_busy0", 32'(busy), 1);
    cyc();
    check("fill_busy1", 32'(busy), 1);
    check("fill_cnt10", 32'(alive_count), 10);
    cyc();
    check("fill_busy2", 32'(busy), 1);
    cyc();
    check("fill_done", 32'(busy), 0);
    check("full_mask", 32'(alive), 32'h3FFF_FFFF);
    check("full_cnt", 32'(alive_count), 30);
    check("ready_play", 32'(hit_ready), 1);

    hit(2, 4);
    check("h24_bit", 32'(alive[2][4]), 0);
    check("h24_cnt", 32'(alive_count), 29);
    check("h24_score", 32'(score), 10);
    check("h24_kp", 32'(kill_pulse), 1);
    cyc();
    check("kp_once", 32'(kill_pulse), 0);
    hit(2, 4);
    check("rep_cnt", 32'(alive_count), 29);
    check("rep_score", 32'(score), 10);

    hit(0, 0);
    check("h00_score", 32'(score), 40);
    hit(1, 9);
    check("h19_score", 32'(score), 60);
    hit(0, 12);
    check("oor_cnt", 32'(alive_count), 27);
    check("oor_kp", 32'(kill_pulse), 0);

    kill_all();
    check("last_wc", 32'(wave_cleared), 1);
    check("last_kp", 32'(kill_pulse), 1);
    check("last_mask", 32'(alive), 0);
    check("last_ready", 32'(hit_ready), 0);
    check("last_score", 32'(score), 600);
    hit(0, 0);
    check("done_score", 32'(score), 600);

    wave();
    new_wave = 1'b1;
    hit_valid = 1'b1;
    hit_row = 2'd1;
    hit_col = 4'd1;
    #1;
    check("abort_ready", 32'(hit_ready), 0);
    cyc();
    new_wave = 1'b0;
    hit_valid = 1'b0;
    check("abort_busy", 32'(busy), 1);
    check("abort_cnt", 32'(alive_count), 0);
    check("abort_score", 32'(score), 600);
    repeat (3) cyc();
    check("refill_cnt", 32'(alive_count), 30);

    score_clr = 1'b1;
    hit(0, 0);
    score_clr = 1'b0;
    check("clrkill_score", 32'(score), 0);
    check("clrkill_kp", 32'(kill_pulse), 1);
    hit(0, 1);
    check("post_clr", 32'(score), 30);

    score_clr = 1'b1;
    cyc();
    score_clr = 1'b0;
    for (int c = 0; c < 9; c++) hit(2, c);
    lit_score("s90", 16'h0090, 16'd90);
    hit(1, 0);
    lit_score("s110_carry", 16'h0110, 16'd110);

    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check("rstplay_score", 32'(score), 0);
    check("rstplay_mask", 32'(alive), 0);
    check("rstplay_ready", 32'(hit_ready), 0);

    new_wave = 1'b1;
    cyc();
    new_wave = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check("rstfill_busy", 32'(busy), 0);
    check("rstfill_cnt", 32'(alive_count), 0);

    repeat (16) begin
      wave();
      kill_all();
    end
    lit_score("s9600", 16'h9600, 16'd9600);
    wave();
    for (int c = 0; c < C; c++) hit(0, c);
    for (int c = 0; c < 3; c++) hit(1, c);
    for (int c = 0; c < 3; c++) hit(2, c);
    lit_score("s9990", 16'h9990, 16'd9990);
    wave();
    hit(0, 0);
    lit_score("s_sat_or_10020", 16'h9999, 16'd10020);

`ifdef INVADER_SCORE_BCD_EN
    hit(0, 1);
    check("bcd_hold", 32'(score), 32'h9999);
`else
    for (int w = 0; w < 120 && mscore < MAXS; w++) begin
      wave();
      kill_all();
    end
    check("bin_sat", 32'(score), 32'hFFFF);
    hit(0, 0);
    wave();
    hit(0, 0);
    check("bin_hold", 32'(score), 32'hFFFF);
`endif

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
